// File: rtl/inv_addkey_mixcol_seq.sv
// AES decryption round stage: AddRoundKey followed by a multi-cycle InvMixColumns.
// The block is XORed with the round key on accept, then mixed COLS_PER_CYCLE columns per
// cycle in place; skip_mix (final round) goes straight to the output.
// Optional completed-block counter: define INV_MIXCOL_BLKCNT_EN.
module inv_addkey_mixcol_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [15:0]  blk_cnt
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] ColStep = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LastCol = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {StIdle, StMix, StDone} state_e;

    state_e       state_q;
    logic [127:0] st_q;
    logic [127:0] st_mix;
    logic [1:0]   col_q;
    logic         in_ready_q;
    logic         out_valid_q;

    // GF(2^8) multiply by 2, reduction polynomial 0x11B
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns of one column; row 0 is the top byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Column c sits at bit offset (3-c)*32, i.e. {~c, 5'b0}
    function automatic logic [6:0] col_base(input logic [1:0] c);
        return {~c, 5'b0};
    endfunction

    // Mix the window of columns starting at col_q; other columns pass through
    always_comb begin
        st_mix = st_q;
        for (int k = 0; k < int'(COLS_PER_CYCLE); k++) begin
            st_mix[col_base(col_q + 2'(k)) +: 32] = inv_mix_col(st_q[col_base(col_q + 2'(k)) +: 32]);
        end
    end

    // Control FSM with registered handshake outputs and in-place state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            st_q        <= '0;
            col_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        st_q       <= in_state ^ in_key;
                        col_q      <= '0;
                        in_ready_q <= 1'b0;
                        // skip_mix only steers this transition, so it needs no register
                        if (skip_mix) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StMix;
                        end
                    end
                end
                StMix: begin
                    st_q  <= st_mix;
                    col_q <= col_q + ColStep;
                    if (col_q == LastCol) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = st_q;

`ifdef INV_MIXCOL_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    // Count output handshakes, wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`else
    assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_inv_addkey_mixcol_seq.sv
// Bench for inv_addkey_mixcol_seq: three instances (COLS_PER_CYCLE = 1, 2, 4), a driver that
// pushes expected results and a per-instance monitor that pops and compares on each output.
module tb_inv_addkey_mixcol_seq;

    localparam logic [127:0] V1S = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V1E = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] K2  = 128'hffffffff_00000000_11111111_a5a5a5a5;
    localparam logic [127:0] V3S = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V3K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V3E = 128'h00102030405060708090a0b0c0d0e0f0;
`ifdef INV_MIXCOL_BLKCNT_EN
    localparam logic [127:0] ExpCnt = 128'd3;
`else
    localparam logic [127:0] ExpCnt = 128'd0;
`endif

    typedef struct {
        logic [127:0] data;
        int unsigned  rise;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic [127:0] in_key    [3];
    logic         skip_mix  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic [15:0]  blk_cnt   [3];

    exp_t        sb [3][$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_addkey_mixcol_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_key    (in_key[g]),
            .skip_mix  (skip_mix[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .blk_cnt   (blk_cnt[g])
        );
    end

    task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %h, expected %h", nm, d, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int d);
        n_chk++;
        n_fail++;
        $display("FAIL %s (dut %0d): bound expired or unexpected event", nm, d);
    endtask

    // Monitor: pops on each rising out_valid; checks data, latency, hold under stall
    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin : mon
            exp_t         e;
            logic         prev_hs = 1'b0;
            logic         prev_stall = 1'b0;
            logic         ov_prev = 1'b0;
            logic [127:0] prev_data = '0;
            forever begin
                @(negedge clk);
                #1;
                if (rst) begin
                    prev_hs = 1'b0;
                    prev_stall = 1'b0;
                    ov_prev = 1'b0;
                end else begin
                    if (prev_hs) chk("valid drops after handshake", g, out_valid[g], 0);
                    if (prev_stall) begin
                        chk("valid held under stall", g, out_valid[g], 1);
                        chk("data held under stall", g, out_state[g], prev_data);
                    end
                    if (out_valid[g] && !ov_prev) begin
                        if (sb[g].size() == 0) begin
                            fail_now("unexpected output", g);
                        end else begin
                            e = sb[g].pop_front();
                            chk("out_state", g, out_state[g], e.data);
                            chk("out_valid rise cycle", g, cyc, e.rise);
                        end
                    end
                    prev_hs = out_valid[g] && out_ready[g];
                    prev_stall = out_valid[g] && !out_ready[g];
                    prev_data = out_state[g];
                    ov_prev = out_valid[g];
                end
            end
        end
    end

    // Offer one block; expected output rises 4/C cycles after the accept edge (0 if skipped)
    task automatic send(input int d, input logic [127:0] st, input logic [127:0] key,
                        input logic sk, input logic [127:0] exp, output int unsigned acc);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_state[d] = st;
        in_key[d]   = key;
        skip_mix[d] = sk;
        while (!in_ready[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        acc = 0;
        if (!in_ready[d]) begin
            fail_now("accept timeout", d);
        end else begin
            acc = cyc + 1;
            e.data = exp;
            e.rise = acc + (sk ? 0 : 4 / (1 << d));
            sb[d].push_back(e);
            @(negedge clk);
        end
        // Garbage after accept must not disturb the block in flight
        in_valid[d] = 1'b0;
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
        in_key[d]   = {$urandom, $urandom, $urandom, $urandom};
        skip_mix[d] = 1'($urandom);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (sb[d].size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb[d].size() > 0) fail_now("drain timeout", d);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned acc, acc_b, hs_a;
        int          n;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            in_state[d] = '0;
            in_key[d] = '0;
            skip_mix[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("reset in_ready", d, in_ready[d], 1);
            chk("reset out_valid", d, out_valid[d], 0);
            chk("reset out_state", d, out_state[d], 0);
            chk("reset blk_cnt", d, blk_cnt[d], 0);
        end
        #10 rst = 1'b0;

        // Mix with zero key, then key applied before mix, then final-round bypass
        send(0, V1S, '0, 1'b0, V1E, acc);
        send(0, V1S ^ K2, K2, 1'b0, V1E, acc);
        send(0, V3S, V3K, 1'b1, V3E, acc);
        drain(0);

        // Backpressure: output stalled 10 cycles while a new block is offered
        out_ready[0] = 1'b0;
        send(0, V1S, '0, 1'b0, V1E, acc);
        hs_a = 0;
        fork
            send(0, V3S, V3K, 1'b1, V3E, acc_b);
            begin
                n = 0;
                while (!out_valid[0] && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                if (!out_valid[0]) fail_now("stall valid timeout", 0);
                repeat (10) begin
                    @(negedge clk);
                    chk("in_ready low while stalled", 0, in_ready[0], 0);
                end
                out_ready[0] = 1'b1;
                hs_a = cyc + 1;
            end
        join
        chk("next accept right after handshake", 0, acc_b, hs_a + 1);
        drain(0);

        // Reset two cycles into MIX, between clock edges
        send(0, V1S, '0, 1'b0, V1E, acc);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("mid-mix reset out_valid", d, out_valid[d], 0);
            chk("mid-mix reset out_state", d, out_state[d], 0);
            chk("mid-mix reset in_ready", d, in_ready[d], 1);
        end
        sb[0].delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Wider instances: same data, shorter latency
        for (int d = 1; d < 3; d++) begin
            send(d, V1S, '0, 1'b0, V1E, acc);
            send(d, V1S ^ K2, K2, 1'b0, V1E, acc);
            send(d, V3S, V3K, 1'b1, V3E, acc);
            drain(d);
        end

        // Block counter over three blocks, then cleared by reset
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        send(0, V1S, '0, 1'b0, V1E, acc);
        send(0, V1S ^ K2, K2, 1'b0, V1E, acc);
        send(0, V3S, V3K, 1'b1, V3E, acc);
        drain(0);
        chk("blk_cnt after 3 blocks", 0, blk_cnt[0], ExpCnt);
        @(negedge clk) rst = 1'b1;
        #1 chk("blk_cnt after reset", 0, blk_cnt[0], 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int d = 0; d < 3; d++) begin
            if (sb[d].size() != 0) fail_now("outputs never seen", d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
